// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types for the execute stage: word widths, decoded opcode structs,
// FSM state and instruction-class enums, plus the instruction-class decoder.
package pdp8_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 12;

  typedef struct packed {
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic CLA_CLL;
    logic CMA;
    logic CML;
    logic IAC;
    logic RAR;
    logic RAL;
    logic HLT;
    logic NOP;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {StIdle, StRdWait, StExe, StWr, StHalt} exec_state_e;

  typedef enum logic [2:0] {
    InsNop, InsAnd, InsTad, InsIsz, InsDca, InsJms, InsJmp, InsOp7
  } ins_e;

  // mem_bits = {AND,TAD,ISZ,DCA,JMS,JMP}; ambiguous or empty encodings become NOP.
  function automatic ins_e decode_ins(input logic [5:0] mem_bits, input logic op7_any);
    ins_e ins;
    ins = InsNop;
    if (mem_bits == 6'b000000) begin
      ins = op7_any ? InsOp7 : InsNop;
    end else if (!op7_any) begin
      case (mem_bits)
        6'b100000: ins = InsAnd;
        6'b010000: ins = InsTad;
        6'b001000: ins = InsIsz;
        6'b000100: ins = InsDca;
        6'b000010: ins = InsJms;
        6'b000001: ins = InsJmp;
        default:   ins = InsNop;
      endcase
    end
    return ins;
  endfunction

endpackage

// File: rtl/op7_alu.sv
// Group-1 operate microop evaluation on the 13-bit {L,AC} pair, applied in
// the fixed order clear, complement, increment, rotate.
module op7_alu
  import pdp8_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_WIDTH
) (
  input  logic [DATA_W-1:0] ac,
  input  logic              link,
  input  pdp_op7_opcode_s   op7,
  output logic [DATA_W-1:0] new_ac,
  output logic              new_link
);

  logic [DATA_W:0] lac;
  logic            unused_op7;

  assign unused_op7 = op7.HLT ^ op7.NOP;

  always_comb begin
    lac = {link, ac};
    if (op7.CLA_CLL) lac = '0;
    if (op7.CMA)     lac[DATA_W-1:0] = ~lac[DATA_W-1:0];
    if (op7.CML)     lac[DATA_W] = ~lac[DATA_W];
    if (op7.IAC)     lac = lac + (DATA_W + 1)'(1);
    if (op7.RAR)     lac = {lac[0], lac[DATA_W:1]};
    if (op7.RAL)     lac = {lac[DATA_W-1:0], lac[DATA_W]};
    new_ac   = lac[DATA_W-1:0];
    new_link = lac[DATA_W];
  end

endmodule

// File: rtl/exec_mem_ref.sv
// PDP-8 execute stage for memory-reference and group-1 operate instructions.
// Owns AC, L and PC and sequences operand reads/writes to memory.
module exec_mem_ref
  import pdp8_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ifd_valid,
  input  pdp_mem_opcode_s   pdp_mem_opcode,
  input  pdp_op7_opcode_s   pdp_op7_opcode,
  output logic              stall,
  output logic [ADDR_W-1:0] PC_value,
  output logic              exec_rd_req,
  output logic [ADDR_W-1:0] exec_rd_addr,
  input  logic [DATA_W-1:0] exec_rd_data,
  output logic              exec_wr_req,
  output logic [ADDR_W-1:0] exec_wr_addr,
  output logic [DATA_W-1:0] exec_wr_data,
  output logic [DATA_W-1:0] ac,
  output logic              link,
  output logic              halted
);

  localparam logic [1:0] RdLatCnt = 2'(RD_LAT);

  exec_state_e       state_q, state_d;
  ins_e              ins_q, ins_d;
  pdp_op7_opcode_s   op7_q, op7_d;
  logic [ADDR_W-1:0] ea_q, ea_d, pc_q, pc_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] ac_q, ac_d, mdata_q, mdata_d, wr_data_q, wr_data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              link_q, link_d, stall_q, stall_d, halted_q, halted_d;
  logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [DATA_W-1:0] alu_ac, isz_val;
  logic              alu_link;
  logic [DATA_W:0]   tad_sum;
  logic [5:0]        mem_bits;
  logic [ADDR_W-1:0] pc_inc;

  assign mem_bits = {pdp_mem_opcode.AND, pdp_mem_opcode.TAD, pdp_mem_opcode.ISZ,
                     pdp_mem_opcode.DCA, pdp_mem_opcode.JMS, pdp_mem_opcode.JMP};
  assign tad_sum  = {1'b0, ac_q} + {1'b0, mdata_q};
  assign isz_val  = mdata_q + DATA_W'(1);
  assign pc_inc   = pc_q + ADDR_W'(1);

  op7_alu #(
    .DATA_W(DATA_W)
  ) u_op7_alu (
    .ac      (ac_q),
    .link    (link_q),
    .op7     (op7_q),
    .new_ac  (alu_ac),
    .new_link(alu_link)
  );

  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    op7_d     = op7_q;
    ea_d      = ea_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    link_d    = link_q;
    mdata_d   = mdata_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    halted_d  = halted_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (ifd_valid && !stall_q) begin
          ins_d   = decode_ins(mem_bits, pdp_op7_opcode != '0);
          op7_d   = pdp_op7_opcode;
          ea_d    = pdp_mem_opcode.mem_inst_addr;
          stall_d = 1'b1;
          if (ins_d == InsAnd || ins_d == InsTad || ins_d == InsIsz) begin
            rd_req_d  = 1'b1;
            rd_addr_d = pdp_mem_opcode.mem_inst_addr;
            cnt_d     = 2'd0;
            state_d   = StRdWait;
          end else begin
            state_d = StExe;
          end
        end
      end
      StRdWait: begin
        // One extra wait cycle beyond RD_LAT so read data is sampled once it is valid.
        if (cnt_q == RdLatCnt) begin
          mdata_d = exec_rd_data;
          state_d = StExe;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StExe: begin
        state_d = StIdle;
        stall_d = 1'b0;
        pc_d    = pc_inc;
        unique case (ins_q)
          InsAnd: ac_d = ac_q & mdata_q;
          InsTad: begin
            ac_d   = tad_sum[DATA_W-1:0];
            link_d = link_q ^ tad_sum[DATA_W];
          end
          InsIsz, InsDca, InsJms: begin
            wr_req_d  = 1'b1;
            wr_addr_d = ea_q;
            wr_data_d = (ins_q == InsIsz) ? isz_val :
                        (ins_q == InsDca) ? ac_q : DATA_W'(pc_inc);
            stall_d   = 1'b1;
            pc_d      = pc_q;
            state_d   = StWr;
          end
          InsJmp: pc_d = ea_q;
          InsOp7: begin
            ac_d   = alu_ac;
            link_d = alu_link;
            if (op7_q.HLT) begin
              halted_d = 1'b1;
              stall_d  = 1'b1;
              state_d  = StHalt;
            end
          end
          default: ;
        endcase
      end
      StWr: begin
        state_d = StIdle;
        stall_d = 1'b0;
        pc_d    = pc_inc;
        if (ins_q == InsIsz && wr_data_q == '0) pc_d = pc_q + ADDR_W'(2);
        if (ins_q == InsDca) ac_d = '0;
        if (ins_q == InsJms) pc_d = ea_q + ADDR_W'(1);
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ins_q     <= InsNop;
      op7_q     <= '0;
      ea_q      <= '0;
      pc_q      <= base_addr;
      ac_q      <= '0;
      link_q    <= 1'b0;
      mdata_q   <= '0;
      cnt_q     <= 2'd0;
      stall_q   <= 1'b0;
      halted_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      op7_q     <= op7_d;
      ea_q      <= ea_d;
      pc_q      <= pc_d;
      ac_q      <= ac_d;
      link_q    <= link_d;
      mdata_q   <= mdata_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // A decoder presenting work while busy is a protocol slip; the request is dropped.
  always @(posedge clk) begin
    assert (reset || !(ifd_valid && stall_q))
      else $warning("ifd_valid dropped while stall is high");
  end

  assign stall        = stall_q;
  assign PC_value     = pc_q;
  assign exec_rd_req  = rd_req_q;
  assign exec_rd_addr = rd_addr_q;
  assign exec_wr_req  = wr_req_q;
  assign exec_wr_addr = wr_addr_q;
  assign exec_wr_data = wr_data_q;
  assign ac           = ac_q;
  assign link         = link_q;
  assign halted       = halted_q;

endmodule
